// File: rtl/adc_sample_sink.sv
// adc_sample_sink: captures SAR ADC results on each end-of-conversion rise into a
// first-word-fall-through FIFO and streams them out on a valid/ready interface.
// Overflow is tracked by a sticky flag and a saturating drop counter.
// Optional build macro ADC_SINK_TSTAMP_EN: stores a free-running timestamp with
// every sample and presents it on m_tstamp alongside m_data.
module adc_sample_sink #(
    parameter int NUM_BITS = 4,
    parameter int DEPTH    = 8,
    parameter int DROP_W   = 8,
    parameter int TS_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BITS-1:0]    adc_d_out,
    input  logic                   adc_eoc,
    input  logic                   enable,
    input  logic                   flush,
    input  logic                   clear_stat,
    output logic [NUM_BITS-1:0]    m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_cnt
`ifdef ADC_SINK_TSTAMP_EN
    ,
    output logic [TS_W-1:0]        m_tstamp
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
`ifdef ADC_SINK_TSTAMP_EN
    localparam int ENT_W = TS_W + NUM_BITS;
`else
    localparam int ENT_W = NUM_BITS;
`endif
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0]  LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

    logic                r_eoc_q;
    logic [ENT_W-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;
    logic [ENT_W-1:0]    r_head;
    logic                r_valid;
    logic                r_overflow;
    logic [DROP_W-1:0]   r_drop_cnt;

    logic                w_rise;
    logic                w_push_req;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [PTR_W-1:0]    w_wr_nxt;
    logic [PTR_W-1:0]    w_rd_nxt;
    logic [LVL_W-1:0]    w_level_nxt;
    logic [ENT_W-1:0]    w_entry;
    logic [ENT_W-1:0]    w_head_nxt;
    logic                w_ovf_nxt;
    logic [DROP_W-1:0]   w_drop_nxt;

`ifdef ADC_SINK_TSTAMP_EN
    logic [TS_W-1:0]     r_ts;

    // Free-running timestamp sampled into each captured entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts <= {TS_W{1'b0}};
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    assign w_entry  = {r_ts, adc_d_out};
    assign m_tstamp = r_head[ENT_W-1:NUM_BITS];
`else
    assign w_entry  = adc_d_out;
`endif

    // Edge detect on EOC and resolve push/pop/drop; flush overrides everything
    always_comb begin
        w_rise     = adc_eoc & ~r_eoc_q;
        w_push_req = w_rise & enable;
        w_full     = (r_level == LVL_FULL);
        w_pop      = r_valid & m_ready;
        w_push     = 1'b0;
        w_drop     = 1'b0;
        if (flush) begin
            w_push = 1'b0;
            w_drop = 1'b0;
        end else begin
            // at full, a same-cycle pop frees the slot the new sample needs
            w_push = w_push_req & (~w_full | w_pop);
            w_drop = w_push_req & w_full & ~w_pop;
        end
    end

    // Next pointers and occupancy
    always_comb begin
        w_wr_nxt    = r_wr_ptr;
        w_rd_nxt    = r_rd_ptr;
        w_level_nxt = r_level;
        if (flush) begin
            w_wr_nxt    = PTR_ZERO;
            w_rd_nxt    = PTR_ZERO;
            w_level_nxt = LVL_ZERO;
        end else begin
            if (w_push) begin
                w_wr_nxt = r_wr_ptr + PTR_ONE;
            end else begin
                w_wr_nxt = r_wr_ptr;
            end
            if (w_pop) begin
                w_rd_nxt = r_rd_ptr + PTR_ONE;
            end else begin
                w_rd_nxt = r_rd_ptr;
            end
            if (w_push && !w_pop) begin
                w_level_nxt = r_level + LVL_ONE;
            end else if (w_pop && !w_push) begin
                w_level_nxt = r_level - LVL_ONE;
            end else begin
                w_level_nxt = r_level;
            end
        end
    end

    // Head-of-queue value for next cycle; the incoming sample bypasses storage
    // when it lands directly in the head slot so latency stays at one cycle
    always_comb begin
        w_head_nxt = r_head;
        if (w_level_nxt == LVL_ZERO) begin
            w_head_nxt = r_head;
        end else if (w_push && (r_wr_ptr == w_rd_nxt)) begin
            w_head_nxt = w_entry;
        end else begin
            w_head_nxt = r_mem[w_rd_nxt];
        end
    end

    // Overflow statistics; a clear coinciding with a drop leaves a count of one
    always_comb begin
        w_ovf_nxt  = r_overflow;
        w_drop_nxt = r_drop_cnt;
        if (clear_stat) begin
            w_ovf_nxt = w_drop;
            if (w_drop) begin
                w_drop_nxt = DROP_ONE;
            end else begin
                w_drop_nxt = {DROP_W{1'b0}};
            end
        end else if (w_drop) begin
            w_ovf_nxt = 1'b1;
            if (r_drop_cnt == DROP_MAX) begin
                w_drop_nxt = r_drop_cnt;
            end else begin
                w_drop_nxt = r_drop_cnt + DROP_ONE;
            end
        end else begin
            w_ovf_nxt  = r_overflow;
            w_drop_nxt = r_drop_cnt;
        end
    end

    // Sample storage; entries are qualified by the level so no reset is needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Control, output and statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eoc_q    <= 1'b0;
            r_wr_ptr   <= PTR_ZERO;
            r_rd_ptr   <= PTR_ZERO;
            r_level    <= LVL_ZERO;
            r_head     <= {ENT_W{1'b0}};
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= {DROP_W{1'b0}};
        end else begin
            r_eoc_q    <= adc_eoc;
            r_wr_ptr   <= w_wr_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_level    <= w_level_nxt;
            r_head     <= w_head_nxt;
            r_valid    <= (w_level_nxt != LVL_ZERO);
            r_overflow <= w_ovf_nxt;
            r_drop_cnt <= w_drop_nxt;
        end
    end

    assign m_data     = r_head[NUM_BITS-1:0];
    assign m_valid    = r_valid;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_adc_sample_sink.sv
// Scoreboard bench for adc_sample_sink: a queue-based reference model predicts
// accepted samples, occupancy and overflow statistics; a negedge monitor pops
// expected samples on every handshake and compares.
module tb_adc_sample_sink;
    localparam int NB     = 4;
    localparam int DEPTH  = 8;
    localparam int DROP_W = 8;
    localparam int TS_W   = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NB-1:0]     adc_d_out = 4'h0;
    logic              adc_eoc = 1'b0;
    logic              enable = 1'b0;
    logic              flush = 1'b0;
    logic              clear_stat = 1'b0;
    logic              m_ready = 1'b0;
    logic [NB-1:0]     m_data;
    logic              m_valid;
    logic [3:0]        fifo_level;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;
`ifdef ADC_SINK_TSTAMP_EN
    logic [TS_W-1:0]   m_tstamp;
`endif

    adc_sample_sink #(.NUM_BITS(NB), .DEPTH(DEPTH), .DROP_W(DROP_W), .TS_W(TS_W)) dut (
        .clk(clk), .rst_n(rst_n), .adc_d_out(adc_d_out), .adc_eoc(adc_eoc),
        .enable(enable), .flush(flush), .clear_stat(clear_stat),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .fifo_level(fifo_level), .overflow(overflow), .drop_cnt(drop_cnt)
`ifdef ADC_SINK_TSTAMP_EN
        , .m_tstamp(m_tstamp)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [NB-1:0] q_model[$];
    logic [NB-1:0] exp_q[$];
    bit            prev_eoc;
    bit            mdl_ovf;
    int            mdl_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        q_model.delete();
        exp_q.delete();
        prev_eoc = 1'b0;
        mdl_ovf  = 1'b0;
        mdl_drop = 0;
    endtask

    // advance the model by one clock edge using the inputs applied for it
    task automatic model_update();
        bit rise, pop, full, drop;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rise     = adc_eoc && !prev_eoc;
        prev_eoc = adc_eoc;
        pop      = (q_model.size() > 0) && m_ready;
        full     = (q_model.size() == DEPTH);
        drop     = 1'b0;
        if (flush) begin
            q_model.delete();
            exp_q.delete();
        end else begin
            if (pop) void'(q_model.pop_front());
            if (rise && enable) begin
                if (!full || pop) begin
                    q_model.push_back(adc_d_out);
                    exp_q.push_back(adc_d_out);
                end else begin
                    drop = 1'b1;
                end
            end
        end
        if (clear_stat) begin
            mdl_ovf  = drop;
            mdl_drop = drop ? 1 : 0;
        end else if (drop) begin
            mdl_ovf  = 1'b1;
            mdl_drop = (mdl_drop >= 255) ? 255 : mdl_drop + 1;
        end
    endtask

    // apply inputs, let one edge pass, then update the model (at posedge+1)
    task automatic cyc(input bit eoc, input logic [NB-1:0] d, input bit en,
                       input bit rdy, input bit fl, input bit cs);
        adc_eoc    = eoc;
        adc_d_out  = d;
        enable     = en;
        m_ready    = rdy;
        flush      = fl;
        clear_stat = cs;
        @(posedge clk);
        #1;
        model_update();
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_valid", m_valid, 0);
        chk("rst_mid_level", fifo_level, 0);
        chk("rst_mid_drop", drop_cnt, 0);
`ifdef ADC_SINK_TSTAMP_EN
        chk("rst_mid_tstamp", m_tstamp, 0);
`endif
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // monitor: compare status every cycle and pop the scoreboard on handshake
    initial begin
        logic [NB-1:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("mon_valid", m_valid, (q_model.size() != 0));
                chk("mon_level", fifo_level, q_model.size());
                chk("mon_overflow", overflow, mdl_ovf);
                chk("mon_drop_cnt", drop_cnt, mdl_drop);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL mon_data: got %0d, expected no sample", m_data);
                    end else begin
                        exp = exp_q.pop_front();
                        chk("mon_data", m_data, exp);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int bias;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", m_valid, 0);
        chk("reset_data", m_data, 0);
        chk("reset_level", fifo_level, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_drop", drop_cnt, 0);
        #2;
        rst_n = 1'b1;

        // basic capture
        cyc(1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("basic_valid", m_valid, 1);
        chk("basic_data", m_data, 4'hA);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("basic_level", fifo_level, 0);

        // level EOC gives one capture
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("level_eoc_level", fifo_level, 1);
        chk("level_eoc_data", m_data, 4'h3);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // overflow: 10 pulses into 8 entries
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 4'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 4'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("ovf_level", fifo_level, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop", drop_cnt, 2);
        chk("ovf_head", m_data, 0);

        // push and pop together at full
        cyc(1'b1, 4'hC, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("full_pp_level", fifo_level, 8);
        chk("full_pp_drop", drop_cnt, 2);
        for (int i = 0; i < 8; i++) cyc(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("drain_level", fifo_level, 0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("clear_flag", overflow, 0);
        chk("clear_drop", drop_cnt, 0);

        // flush with a simultaneous rise, then disabled capture
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 4'(i + 4), 1'b1, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("pre_flush_level", fifo_level, 3);
        cyc(1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_valid", m_valid, 0);
        chk("flush_drop", drop_cnt, 0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("disabled_level", fifo_level, 0);
        chk("disabled_drop", drop_cnt, 0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // clear_stat coinciding with a drop
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 4'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 4'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("clr_drop_flag", overflow, 1);
        chk("clr_drop_cnt", drop_cnt, 1);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // drop counter saturation
        for (int i = 0; i < 260; i++) begin
            cyc(1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("sat_drop", drop_cnt, 255);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("sat_clear_level", fifo_level, 0);
        chk("sat_clear_drop", drop_cnt, 0);

        // reset mid-stream
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 4'(i + 8), 1'b1, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("pre_rst_level", fifo_level, 4);
        mid_reset();
        cyc(1'b1, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_data", m_data, 4'h6);
`ifdef ADC_SINK_TSTAMP_EN
        chk("post_rst_tstamp", m_tstamp, 0);
`endif
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);

        // randomized traffic
        for (int blk = 0; blk < 6; blk++) begin
            case (blk % 3)
                0:       bias = 90;
                1:       bias = 15;
                default: bias = 50;
            endcase
            for (int i = 0; i < 500; i++) begin
                cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 9) != 0), ($urandom_range(0, 99) < bias),
                    ($urandom_range(0, 79) == 0), ($urandom_range(0, 119) == 0));
            end
            if (blk % 2 == 1) mid_reset();
        end

        // final drain
        for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("final_level", fifo_level, 0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
